shift_operand_stage: RTL and testbench
======================================

SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-003 SHALL have port in_valid, input, 1, upstream presents an operand.
REQ-004 SHALL have port in_ready, output, 1, stage accepts when in_valid & in_ready.
REQ-005 SHALL have port ImmFlag, input, 1, instruction I bit (1 = rotated immediate).
REQ-006 SHALL have port Operand2, input, 12, instruction bits [11:0].
REQ-007 SHALL have port RmData, input, 32, value of Rm, valid in the accept cycle.
REQ-008 SHALL have port CarryIn, input, 1, current C flag, sampled in the accept cycle.
REQ-009 SHALL have port RsAddr, output, 4, read address for the Rs read port.
REQ-010 SHALL have port RsData, input, 32, combinational read data for RsAddr.
REQ-011 SHALL have port out_valid, output, 1, shifter operands valid.
REQ-012 SHALL have port out_ready, input, 1, downstream shifter/ALU consumes.
REQ-013 SHALL have ports ShiftInput (32), ShiftAmount (5) and ShiftType (2), all outputs, registered, driving the barrel shifter directly.

Function
REQ-014 SHALL use ShiftType encoding LSL=00, LSR=01, ASR=10, ROR=11.
REQ-015 SHALL implement states IDLE and READ_RS; in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-016 Immediate path (ImmFlag=1): ShiftInput={24'b0,Operand2[7:0]}, ShiftAmount={Operand2[11:8],1'b0}, ShiftType=ROR, out_valid next cycle.
REQ-017 Immediate-shift path (ImmFlag=0, Operand2[4]=0): sh=Operand2[6:5], shamt=Operand2[11:7], input=RmData, latency 1.
REQ-018 In the immediate-shift path, LSR #0 SHALL be treated as LSR #32 and emit ShiftInput=0.
REQ-019 In the immediate-shift path, ASR #0 SHALL be treated as ASR #32 and emit ShiftInput={32{RmData[31]}}.
REQ-020 In the immediate-shift path, ROR #0 SHALL be treated as RRX and emit ShiftInput={CarryIn,RmData[31:1]}.
REQ-021 Register-shift path (ImmFlag=0, Operand2[4]=1): on accept, capture RmData, sh and Rs=Operand2[11:8], then go to READ_RS.
REQ-022 In READ_RS, RsAddr SHALL equal the captured Rs, RsData[7:0] SHALL be sampled at the end of the cycle, outputs SHALL be loaded, and the state SHALL return to IDLE (latency 2).
REQ-023 In register-shift amount rules, amt=RsData[7:0]: amt=0 SHALL pass Rm unchanged.
REQ-024 In register-shift amount rules, amt>=32 with LSL/LSR SHALL emit ShiftInput=0.
REQ-025 In register-shift amount rules, amt>=32 with ASR SHALL emit sign fill.
REQ-026 In register-shift amount rules, ROR SHALL use amt[4:0], with amt[4:0]=0 passing Rm unchanged.
REQ-027 In register-shift amount rules, amt 1..31 SHALL emit amount amt[4:0] with type sh.
REQ-028 Whenever emitted ShiftAmount=0, ShiftType SHALL be emitted as LSL, so the downstream never sees ROR #0.
REQ-029 RsAddr SHALL be 0 outside READ_RS.
REQ-030 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-031 out_valid SHALL clear on handshake unless a new result loads in the same cycle.
REQ-032 Back-to-back single-cycle operands SHALL sustain 1 per cycle when out_ready=1.
REQ-033 The output register SHALL be empty whenever the state is READ_RS (guaranteed by REQ-015).
REQ-034 Combinational paths in->out SHALL be limited to in_ready (from state, out_valid and out_ready) and RsAddr (from state and captured Rs).

Reset
REQ-035 While reset=0 at a clock edge: state=IDLE, out_valid=0, ShiftInput=0, ShiftAmount=0, ShiftType=LSL, captured Rm/Rs/sh cleared.
REQ-036 Reset asserted during READ_RS SHALL discard the pending operand with no output produced.
REQ-037 in_ready SHALL be 0 during the cycle reset is low.

Structure
REQ-038 Shared package SHALL hold the ShiftType constants (LSL/LSR/ASR/ROR) and the state encoding (IDLE, READ_RS).
REQ-039 One combinational sub-module shift_amount_norm SHALL map (sh, amount[7:0], Rm, CarryIn, is_imm_shift) to (ShiftInput, ShiftAmount, ShiftType) and be shared by both register paths.

Verification
REQ-040 ImmFlag=1, Operand2=0x4FF -> next cycle ShiftInput=0x000000FF, ShiftAmount=8, ShiftType=ROR, out_valid=1.
REQ-041 Operand2=0x023, RmData=0x80000000 -> ShiftInput=0, ShiftAmount=0, ShiftType=LSL.
REQ-042 Operand2=0x043, RmData=0x80000000 -> ShiftInput=0xFFFFFFFF, ShiftAmount=0, ShiftType=LSL.
REQ-043 Operand2=0x060, RmData=0x00000002, CarryIn=1 -> ShiftInput=0x80000001, ShiftAmount=0, ShiftType=LSL.
REQ-044 Register shift, Operand2=0x213, RsData=0x00000104 -> RsAddr=2 in READ_RS, out_valid 2 cycles after accept, amount=4, type=LSL, in_ready=0 in READ_RS.
REQ-045 Register shift, Operand2=0x233, RsData=0x28 -> ShiftInput=0.
REQ-046 Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; release -> one handshake, queued operand issues next cycle.
REQ-047 reset=0 asserted in READ_RS -> out_valid stays 0 and state=IDLE after the edge.

Source files
------------

// File: rtl/shift_operand_stage_pkg.sv
// Shared definitions for the shifter operand stage.
//   - Barrel-shifter ShiftType encodings (LSL/LSR/ASR/ROR)
//   - Operand-stage FSM state encoding (IDLE/READ_RS)
package shift_operand_stage_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_READ_RS = 1'b1;

endpackage

// File: rtl/shift_operand_stage_amount_norm.sv
// shift_amount_norm: combinational normalisation of a register-operand shift
// into the (input, amount, type) triple the barrel shifter expects.
// Shifts that are fully resolved here (LSR/ASR #32, RRX, large register
// amounts) are pre-computed into shift_input with a zero amount, and any
// zero amount is always reported as LSL so the shifter never sees ROR #0.
// Ports:
//   sh           in  2   requested shift type
//   amount       in  8   immediate shamt (zero-extended) or Rs[7:0]
//   rm           in  32  value being shifted
//   carry_in     in  1   C flag, used only for RRX
//   is_imm_shift in  1   1 = immediate-shift encoding, 0 = register shift
//   shift_input  out 32  value presented to the shifter
//   shift_amount out 5   shift distance
//   shift_type   out 2   shift type
module shift_amount_norm
   import shift_operand_stage_pkg::*;
(
   input  logic [1:0]  sh,
   input  logic [7:0]  amount,
   input  logic [31:0] rm,
   input  logic        carry_in,
   input  logic        is_imm_shift,
   output logic [31:0] shift_input,
   output logic [4:0]  shift_amount,
   output logic [1:0]  shift_type
);

   logic [31:0] sign_fill_s;
   logic        amt_big_s;

   assign sign_fill_s = {32{rm[31]}};
   assign amt_big_s   = (amount[7:5] != 3'd0);

   // Map the encoded shift onto shifter operands.
   always_comb begin
      shift_input  = rm;
      shift_amount = 5'd0;
      shift_type   = SH_LSL;
      if (is_imm_shift) begin
         if (amount[4:0] == 5'd0) begin
            // A zero immediate amount encodes LSR/ASR #32 and RRX.
            case (sh)
               SH_LSL:  shift_input = rm;
               SH_LSR:  shift_input = 32'd0;
               SH_ASR:  shift_input = sign_fill_s;
               SH_ROR:  shift_input = {carry_in, rm[31:1]};
               default: shift_input = rm;
            endcase
         end else begin
            shift_amount = amount[4:0];
            shift_type   = sh;
         end
      end else begin
         if (amount == 8'd0) begin
            shift_input = rm;
         end else if (sh == SH_ROR) begin
            // Rotation is modulo 32; a multiple of 32 leaves Rm unchanged.
            if (amount[4:0] != 5'd0) begin
               shift_amount = amount[4:0];
               shift_type   = SH_ROR;
            end else begin
               shift_input = rm;
            end
         end else if (amt_big_s) begin
            if (sh == SH_ASR) begin
               shift_input = sign_fill_s;
            end else begin
               shift_input = 32'd0;
            end
         end else begin
            shift_amount = amount[4:0];
            shift_type   = sh;
         end
      end
   end

endmodule

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: decodes the data-processing operand2 field and
// delivers registered barrel-shifter operands with a valid/ready handshake.
// Immediate and immediate-shift forms take one cycle; register-shift forms
// spend a second cycle (READ_RS) reading Rs through the RsAddr/RsData port.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   ImmFlag, Operand2     instruction I bit and bits [11:0]
//   RmData, CarryIn       Rm value and C flag in the accept cycle
//   RsAddr / RsData       Rs read port (address 0 outside READ_RS)
//   out_valid / out_ready downstream handshake
//   ShiftInput, ShiftAmount, ShiftType  registered shifter operands
module shift_operand_stage
   import shift_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        ImmFlag,
   input  logic [11:0] Operand2,
   input  logic [31:0] RmData,
   input  logic        CarryIn,
   output logic [3:0]  RsAddr,
   input  logic [31:0] RsData,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] ShiftInput,
   output logic [4:0]  ShiftAmount,
   output logic [1:0]  ShiftType
);

   logic        state_r;
   logic        out_valid_r;
   logic [31:0] shift_input_r;
   logic [4:0]  shift_amount_r;
   logic [1:0]  shift_type_r;
   logic [31:0] rm_r;
   logic [3:0]  rs_r;
   logic [1:0]  sh_r;

   logic        accept_s;
   logic        is_reg_shift_s;
   logic        load_s;
   logic [1:0]  norm_sh_s;
   logic [7:0]  norm_amount_s;
   logic [31:0] norm_rm_s;
   logic        norm_is_imm_s;
   logic [31:0] norm_input_s;
   logic [4:0]  norm_amount_out_s;
   logic [1:0]  norm_type_s;
   logic [31:0] next_input_s;
   logic [4:0]  next_amount_s;
   logic [1:0]  next_type_s;
   logic        unused_bits;

   // Operand2[3:0] (Rm index) and RsData[31:8] are not needed here.
   assign unused_bits = ^{Operand2[3:0], RsData[31:8]};

   assign in_ready       = reset & (state_r == ST_IDLE) & (~out_valid_r | out_ready);
   assign accept_s       = in_valid & in_ready;
   assign is_reg_shift_s = ~ImmFlag & Operand2[4];
   // READ_RS is only entered with an empty output register, so it always loads.
   assign load_s         = (accept_s & ~is_reg_shift_s) | (state_r == ST_READ_RS);
   assign RsAddr         = (state_r == ST_READ_RS) ? rs_r : 4'd0;

   assign out_valid   = out_valid_r;
   assign ShiftInput  = shift_input_r;
   assign ShiftAmount = shift_amount_r;
   assign ShiftType   = shift_type_r;

   // Select normaliser inputs: captured register-shift operand in READ_RS,
   // live immediate-shift fields otherwise.
   always_comb begin
      norm_sh_s     = Operand2[6:5];
      norm_amount_s = {3'd0, Operand2[11:7]};
      norm_rm_s     = RmData;
      norm_is_imm_s = 1'b1;
      if (state_r == ST_READ_RS) begin
         norm_sh_s     = sh_r;
         norm_amount_s = RsData[7:0];
         norm_rm_s     = rm_r;
         norm_is_imm_s = 1'b0;
      end else begin
         norm_sh_s     = Operand2[6:5];
         norm_amount_s = {3'd0, Operand2[11:7]};
         norm_rm_s     = RmData;
         norm_is_imm_s = 1'b1;
      end
   end

   shift_amount_norm u_norm (
      .sh           (norm_sh_s),
      .amount       (norm_amount_s),
      .rm           (norm_rm_s),
      .carry_in     (CarryIn),
      .is_imm_shift (norm_is_imm_s),
      .shift_input  (norm_input_s),
      .shift_amount (norm_amount_out_s),
      .shift_type   (norm_type_s)
   );

   // Choose the result to load: rotated immediate or normalised shift.
   always_comb begin
      next_input_s  = norm_input_s;
      next_amount_s = norm_amount_out_s;
      next_type_s   = norm_type_s;
      if ((state_r == ST_IDLE) && ImmFlag) begin
         next_input_s  = {24'd0, Operand2[7:0]};
         next_amount_s = {Operand2[11:8], 1'b0};
         // A zero rotation is reported as LSL #0, never ROR #0.
         next_type_s   = (Operand2[11:8] == 4'd0) ? SH_LSL : SH_ROR;
      end else begin
         next_input_s  = norm_input_s;
         next_amount_s = norm_amount_out_s;
         next_type_s   = norm_type_s;
      end
   end

   // FSM and register-shift operand capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         rm_r    <= 32'd0;
         rs_r    <= 4'd0;
         sh_r    <= SH_LSL;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && is_reg_shift_s) begin
                  rm_r    <= RmData;
                  rs_r    <= Operand2[11:8];
                  sh_r    <= Operand2[6:5];
                  state_r <= ST_READ_RS;
               end
            end
            ST_READ_RS: state_r <= ST_IDLE;
            default:    state_r <= ST_IDLE;
         endcase
      end
   end

   // Output register: load new result, clear on handshake, otherwise hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_r    <= 1'b0;
         shift_input_r  <= 32'd0;
         shift_amount_r <= 5'd0;
         shift_type_r   <= SH_LSL;
      end else if (load_s) begin
         out_valid_r    <= 1'b1;
         shift_input_r  <= next_input_s;
         shift_amount_r <= next_amount_s;
         shift_type_r   <= next_type_s;
      end else if (out_ready) begin
         out_valid_r    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: a table of directed operand
// vectors plus hand-written handshake, back-pressure and reset sequences.
module tb_shift_operand_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        ImmFlag;
   logic [11:0] Operand2;
   logic [31:0] RmData;
   logic        CarryIn;
   logic [3:0]  RsAddr;
   logic [31:0] RsData;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ShiftInput;
   logic [4:0]  ShiftAmount;
   logic [1:0]  ShiftType;

   logic [31:0] rs_file [16];
   int total;
   int bad;

   typedef struct {
      logic        imm;
      logic [11:0] op2;
      logic [31:0] rm;
      logic        carry;
      logic [31:0] rs;
      logic [31:0] exp_in;
      logic [4:0]  exp_amt;
      logic [1:0]  exp_type;
   } vec_t;

   vec_t vecs [18];

   shift_operand_stage dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ImmFlag     (ImmFlag),
      .Operand2    (Operand2),
      .RmData      (RmData),
      .CarryIn     (CarryIn),
      .RsAddr      (RsAddr),
      .RsData      (RsData),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ShiftInput  (ShiftInput),
      .ShiftAmount (ShiftAmount),
      .ShiftType   (ShiftType)
   );

   assign RsData = rs_file[RsAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [31:0] e_in,
                            input logic [4:0] e_amt, input logic [1:0] e_type);
      check({name, " valid"}, {31'd0, out_valid}, 32'd1);
      check({name, " input"}, ShiftInput, e_in);
      check({name, " amount"}, {27'd0, ShiftAmount}, {27'd0, e_amt});
      check({name, " type"}, {30'd0, ShiftType}, {30'd0, e_type});
   endtask

   task automatic drive(input logic imm, input logic [11:0] op2,
                        input logic [31:0] rm, input logic c);
      ImmFlag  = imm;
      Operand2 = op2;
      RmData   = rm;
      CarryIn  = c;
      in_valid = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 16; i++) rs_file[i] = 32'd0;
      //          imm   op2      rm            c     rs            exp_in        amt    type
      vecs[0]  = '{1'b1, 12'h4FF, 32'h0,        1'b0, 32'h0,        32'h000000FF, 5'd8,  2'd3};
      vecs[1]  = '{1'b1, 12'h0AB, 32'h0,        1'b0, 32'h0,        32'h000000AB, 5'd0,  2'd0};
      vecs[2]  = '{1'b1, 12'hF01, 32'h0,        1'b0, 32'h0,        32'h00000001, 5'd30, 2'd3};
      vecs[3]  = '{1'b0, 12'h023, 32'h80000000, 1'b0, 32'h0,        32'h00000000, 5'd0,  2'd0};
      vecs[4]  = '{1'b0, 12'h043, 32'h80000000, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0,  2'd0};
      vecs[5]  = '{1'b0, 12'h060, 32'h00000002, 1'b1, 32'h0,        32'h80000001, 5'd0,  2'd0};
      vecs[6]  = '{1'b0, 12'h003, 32'h12345678, 1'b1, 32'h0,        32'h12345678, 5'd0,  2'd0};
      vecs[7]  = '{1'b0, 12'h283, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 5'd5,  2'd0};
      vecs[8]  = '{1'b0, 12'hFE3, 32'hCAFEF00D, 1'b0, 32'h0,        32'hCAFEF00D, 5'd31, 2'd3};
      vecs[9]  = '{1'b0, 12'h043, 32'h7FFFFFFF, 1'b1, 32'h0,        32'h00000000, 5'd0,  2'd0};
      vecs[10] = '{1'b0, 12'h060, 32'h00000003, 1'b0, 32'h0,        32'h00000001, 5'd0,  2'd0};
      vecs[11] = '{1'b0, 12'h213, 32'h11223344, 1'b0, 32'h00000104, 32'h11223344, 5'd4,  2'd0};
      vecs[12] = '{1'b0, 12'h233, 32'h11223344, 1'b0, 32'h00000028, 32'h00000000, 5'd0,  2'd0};
      vecs[13] = '{1'b0, 12'h353, 32'h80000000, 1'b0, 32'h000000FF, 32'hFFFFFFFF, 5'd0,  2'd0};
      vecs[14] = '{1'b0, 12'h473, 32'hA5A5A5A5, 1'b1, 32'h00000020, 32'hA5A5A5A5, 5'd0,  2'd0};
      vecs[15] = '{1'b0, 12'h573, 32'hA5A5A5A5, 1'b0, 32'h00000023, 32'hA5A5A5A5, 5'd3,  2'd3};
      vecs[16] = '{1'b0, 12'h633, 32'h0F0F0F0F, 1'b0, 32'h00000000, 32'h0F0F0F0F, 5'd0,  2'd0};
      vecs[17] = '{1'b0, 12'h753, 32'h0F0F0F0F, 1'b0, 32'h0000001F, 32'h0F0F0F0F, 5'd31, 2'd2};

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ImmFlag   = 1'b0;
      Operand2  = 12'd0;
      RmData    = 32'd0;
      CarryIn   = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", {31'd0, in_ready}, 32'd0);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst input", ShiftInput, 32'd0);
      check("rst amount", {27'd0, ShiftAmount}, 32'd0);
      check("rst type", {30'd0, ShiftType}, 32'd0);
      check("rst rsaddr", {28'd0, RsAddr}, 32'd0);
      reset = 1'b1;
      #1;
      check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

      // Table-driven vectors.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rs_file[vecs[i].op2[11:8]] = vecs[i].rs;
         drive(vecs[i].imm, vecs[i].op2, vecs[i].rm, vecs[i].carry);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (!vecs[i].imm && vecs[i].op2[4]) begin
            check($sformatf("v%0d read_rs valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("v%0d read_rs in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("v%0d rsaddr", i), {28'd0, RsAddr}, {28'd0, vecs[i].op2[11:8]});
            @(posedge clk);
            #1;
         end
         check_out($sformatf("v%0d", i), vecs[i].exp_in, vecs[i].exp_amt, vecs[i].exp_type);
         check($sformatf("v%0d idle rsaddr", i), {28'd0, RsAddr}, 32'd0);
      end

      // Handshake with nothing queued clears out_valid.
      @(posedge clk);
      #1;
      check("drain valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back single-cycle operands at one per cycle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check_out($sformatf("b2b%0d", i - 1), {24'd0, 8'h10 + 8'(i - 1)}, 5'd4, 2'd3);
            check($sformatf("b2b%0d in_ready", i - 1), {31'd0, in_ready}, 32'd1);
         end
         if (i < 3) begin
            drive(1'b1, {4'h2, 8'h10 + 8'(i)}, 32'd0, 1'b0);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;

      // Back-pressure: result A held, operand B queued until release.
      @(negedge clk);
      out_ready = 1'b0;
      drive(1'b1, 12'h4FF, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, 12'h1AB, 32'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_out($sformatf("hold%0d", k), 32'h000000FF, 5'd8, 2'd3);
         check($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_out("queued", 32'h000000AB, 5'd2, 2'd3);
      @(posedge clk);
      #1;
      check("queued drain", {31'd0, out_valid}, 32'd0);

      // Reset asserted in READ_RS discards the pending operand.
      @(negedge clk);
      rs_file[4'h2] = 32'h00000004;
      drive(1'b0, 12'h213, 32'h55555555, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("pre-abort rsaddr", {28'd0, RsAddr}, 32'd2);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort valid", {31'd0, out_valid}, 32'd0);
      check("abort rsaddr", {28'd0, RsAddr}, 32'd0);
      check("abort in_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort after valid", {31'd0, out_valid}, 32'd0);
      check("abort after in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
